// File: rtl/timer_prog.sv
// timer_prog: CH independent N-bit timers (one-shot/periodic) sharing a PW-bit prescaler.
// Define TIMER_PROG_IRQ_EN to add sticky per-channel flags, irq_clr and a combined irq.
module timer_prog #(
    parameter int N  = 6,
    parameter int CH = 2,
    parameter int PW = 4
) (
    input  logic            clk,
    input  logic            res,
    input  logic            en,
    input  logic [PW-1:0]   presc,
    input  logic [CH-1:0]   start,
    input  logic [CH-1:0]   stop,
    input  logic [CH-1:0]   mode,
    input  logic [CH*N-1:0] t_max,
    output logic [CH*N-1:0] t,
    output logic [CH-1:0]   busy,
    output logic [CH-1:0]   done
`ifdef TIMER_PROG_IRQ_EN
    ,
    input  logic [CH-1:0]   irq_clr,
    output logic [CH-1:0]   flag,
    output logic            irq
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [N-1:0]  CNT_ONE = N'(1);
    localparam logic [PW-1:0] P_ONE   = PW'(1);

    logic [PW-1:0] p_q;
    logic          tick;

    // ">=" rather than "==" so lowering presc below the running count wraps at once
    assign tick = en && (p_q >= presc);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            p_q <= '0;
        end else if (en) begin
            p_q <= tick ? '0 : p_q + P_ONE;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_t       state_q, state_d;
        logic [N-1:0] cnt_q, cnt_d;
        logic [N-1:0] tmax_q, tmax_d;
        logic         mode_q, mode_d;
        logic         done_q, done_d;

        always_ff @(posedge clk or posedge res) begin
            if (res) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                tmax_q  <= '0;
                mode_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                tmax_q  <= tmax_d;
                mode_q  <= mode_d;
                done_q  <= done_d;
            end
        end

        // Priority: stop, then start, then terminal count.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            tmax_d  = tmax_q;
            mode_d  = mode_q;
            done_d  = 1'b0;
            if (stop[i]) begin
                state_d = IDLE;
            end else if (start[i]) begin
                state_d = RUN;
                cnt_d   = '0;
                tmax_d  = t_max[i*N +: N];
                mode_d  = mode[i];
            end else if (state_q == RUN && tick) begin
                if (cnt_q != tmax_q) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    done_d = 1'b1;
                    if (mode_q) begin
                        cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        end

        assign t[i*N +: N] = cnt_q;
        assign busy[i]     = (state_q == RUN);
        assign done[i]     = done_q;
    end

`ifdef TIMER_PROG_IRQ_EN
    logic [CH-1:0] flag_q;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            flag_q <= '0;
        end else begin
            flag_q <= done | (flag_q & ~irq_clr);
        end
    end

    assign flag = flag_q;
    assign irq  = |flag_q;
`endif

endmodule

// File: tb/tb_timer_prog.sv
// Self-checking bench for timer_prog: tick-count reference model plus directed literal checks.
// Honours TIMER_PROG_IRQ_EN to also check flag/irq.
module tb_timer_prog;

    localparam int N  = 6;
    localparam int CH = 2;
    localparam int PW = 4;

    logic            clk = 1'b0;
    logic            res;
    logic            en;
    logic [PW-1:0]   presc;
    logic [CH-1:0]   start;
    logic [CH-1:0]   stop;
    logic [CH-1:0]   mode;
    logic [CH*N-1:0] t_max;
    logic [CH*N-1:0] t;
    logic [CH-1:0]   busy;
    logic [CH-1:0]   done;
`ifdef TIMER_PROG_IRQ_EN
    logic [CH-1:0]   irq_clr;
    logic [CH-1:0]   flag;
    logic            irq;
`endif

    int n_cmp = 0;
    int n_err = 0;

    timer_prog #(.N(N), .CH(CH), .PW(PW)) dut (
        .clk     (clk),
        .res     (res),
        .en      (en),
        .presc   (presc),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .t_max   (t_max),
        .t       (t),
        .busy    (busy),
        .done    (done)
`ifdef TIMER_PROG_IRQ_EN
        ,
        .irq_clr (irq_clr),
        .flag    (flag),
        .irq     (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each running channel tracks the number of ticks since its start;
    // the count is that number (one-shot) or that number modulo the period (periodic).
    int m_p;
    bit m_act  [CH];
    int m_k    [CH];
    int m_tmax [CH];
    bit m_per  [CH];
    int m_hold [CH];
    bit m_done [CH];
    bit m_flag [CH];

    function automatic int m_t(int i);
        if (!m_act[i]) return m_hold[i];
        return m_per[i] ? (m_k[i] % (m_tmax[i] + 1)) : m_k[i];
    endfunction

    always @(posedge clk or posedge res) begin
        if (res) begin
            m_p = 0;
            for (int i = 0; i < CH; i++) begin
                m_act[i] = 0; m_k[i] = 0; m_tmax[i] = 0; m_per[i] = 0;
                m_hold[i] = 0; m_done[i] = 0; m_flag[i] = 0;
            end
        end else begin
            bit tk;
            tk = en && (m_p >= int'(presc));
            if (en) m_p = tk ? 0 : m_p + 1;
            for (int i = 0; i < CH; i++) begin
                bit nd;
                nd = 0;
`ifdef TIMER_PROG_IRQ_EN
                m_flag[i] = m_done[i] || (m_flag[i] && !irq_clr[i]);
`endif
                if (stop[i]) begin
                    m_hold[i] = m_t(i);
                    m_act[i]  = 0;
                end else if (start[i]) begin
                    m_act[i]  = 1;
                    m_k[i]    = 0;
                    m_tmax[i] = int'(t_max[i*N +: N]);
                    m_per[i]  = mode[i];
                end else if (m_act[i] && tk) begin
                    m_k[i]++;
                    if (m_k[i] == m_tmax[i] + 1) begin
                        nd = 1;
                        if (m_per[i]) begin
                            m_k[i] = 0;
                        end else begin
                            m_act[i]  = 0;
                            m_hold[i] = m_tmax[i];
                        end
                    end
                end
                m_done[i] = nd;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < CH; i++) begin
            check($sformatf("t[%0d]", i), 64'(t[i*N +: N]), 64'(m_t(i)));
            check($sformatf("busy[%0d]", i), 64'(busy[i]), 64'(m_act[i]));
            check($sformatf("done[%0d]", i), 64'(done[i]), 64'(m_done[i]));
`ifdef TIMER_PROG_IRQ_EN
            check($sformatf("flag[%0d]", i), 64'(flag[i]), 64'(m_flag[i]));
`endif
        end
`ifdef TIMER_PROG_IRQ_EN
        begin
            bit any;
            any = 0;
            for (int i = 0; i < CH; i++) any = any | m_flag[i];
            check("irq", 64'(irq), 64'(any));
        end
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b0; presc = '0; start = '0; stop = '0; mode = '0; t_max = '0;
`ifdef TIMER_PROG_IRQ_EN
        irq_clr = '0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        res = 1'b1;
        step();
        res = 1'b0;
    endtask

    initial begin
        res = 1'b1;
        idle_inputs();
        step();
        step();
        check("reset t", 64'(t), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        res = 1'b0;

        // presc=0, ch0 periodic, t_max=3
        do_reset();
        presc = 4'd0; en = 1'b1; mode = 2'b01; t_max[0 +: N] = 6'd3; start = 2'b01;
        step();
        start = '0;
        check("per t0 after start", 64'(t[0 +: N]), 64'(0));
        for (int e = 1; e <= 8; e++) begin
            step();
            check("per t0", 64'(t[0 +: N]), 64'(e % 4));
            check("per done0", 64'(done[0]), 64'(e % 4 == 0));
            check("per busy0", 64'(busy[0]), 64'(1));
        end

        // presc=2, ch1 one-shot, t_max=2: ticks land on edges 2,5,8 after the start edge
        do_reset();
        presc = 4'd2; en = 1'b1; mode = 2'b00; t_max[N +: N] = 6'd2; start = 2'b10;
        step();
        start = '0;
        for (int e = 1; e <= 11; e++) begin
            step();
            check("os done1", 64'(done[1]), 64'(e == 8));
            check("os busy1", 64'(busy[1]), 64'(e < 8));
            check("os t1", 64'(t[N +: N]), 64'((e < 2) ? 0 : (e < 5) ? 1 : 2));
        end

        // start and stop together while running
        do_reset();
        presc = 4'd0; en = 1'b1; mode = 2'b00; t_max[0 +: N] = 6'd7; start = 2'b01;
        step();
        start = '0;
        step(); step(); step();
        start = 2'b01; stop = 2'b01;
        step();
        start = '0; stop = '0;
        for (int e = 0; e < 4; e++) begin
            check("ss t0", 64'(t[0 +: N]), 64'(3));
            check("ss busy0", 64'(busy[0]), 64'(0));
            check("ss done0", 64'(done[0]), 64'(0));
            step();
        end

        // t_max changed mid-run has no effect until restart
        do_reset();
        presc = 4'd0; en = 1'b1; mode = 2'b01; t_max[0 +: N] = 6'd3; start = 2'b01;
        step();
        start = '0;
        step(); step();
        t_max[0 +: N] = 6'd7;
        for (int e = 3; e <= 12; e++) begin
            step();
            check("tm t0", 64'(t[0 +: N]), 64'(e % 4));
            check("tm done0", 64'(done[0]), 64'(e % 4 == 0));
        end

        // asynchronous reset mid-count
        do_reset();
        presc = 4'd0; en = 1'b1; mode = 2'b01; t_max[0 +: N] = 6'd5; start = 2'b01;
        step();
        start = '0;
        step(); step();
        check("ar t0 before", 64'(t[0 +: N]), 64'(2));
        res = 1'b1;
        #1;
        check("ar t0", 64'(t[0 +: N]), 64'(0));
        check("ar busy0", 64'(busy[0]), 64'(0));
        check("ar done0", 64'(done[0]), 64'(0));
        step();
        res = 1'b0;
        step(); step();
        check("ar no resume", 64'(busy[0]), 64'(0));

`ifdef TIMER_PROG_IRQ_EN
        // done every tick with t_max=0; clear coinciding with done must not win
        do_reset();
        presc = 4'd0; en = 1'b1; mode = 2'b01; t_max[0 +: N] = 6'd0; start = 2'b01;
        step();
        start = '0;
        step();
        check("irq done0", 64'(done[0]), 64'(1));
        check("irq flag0 early", 64'(flag[0]), 64'(0));
        step();
        check("irq flag0", 64'(flag[0]), 64'(1));
        check("irq out", 64'(irq), 64'(1));
        irq_clr = 2'b01;
        step();
        check("irq set wins", 64'(flag[0]), 64'(1));
        stop = 2'b01;
        step();
        stop = '0;
        check("irq flag after stop", 64'(flag[0]), 64'(1));
        step();
        check("irq cleared", 64'(flag[0]), 64'(0));
        check("irq out cleared", 64'(irq), 64'(0));
        irq_clr = '0;
`endif

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) presc = PW'($urandom_range(0, 3));
            for (int i = 0; i < CH; i++) begin
                start[i] = ($urandom_range(0, 24) == 0);
                stop[i]  = ($urandom_range(0, 59) == 0);
                mode[i]  = $urandom_range(0, 1) == 1;
                t_max[i*N +: N] = ($urandom_range(0, 7) == 0) ? N'($urandom) : N'($urandom_range(0, 4));
`ifdef TIMER_PROG_IRQ_EN
                irq_clr[i] = ($urandom_range(0, 3) == 0);
`endif
            end
            res = ($urandom_range(0, 499) == 0);
            step();
        end
        res = 1'b0;
        idle_inputs();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
